dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Memory-stage data-bus bridge between the pipeline's M-stage memory port and an SRAM-like data bus with an `addr_ok`/`data_ok` handshake. It accepts the M-stage request (enable, write flag, byte selects, address, aligned write data), performs one bus transaction, and returns read data. While the transaction is outstanding it raises `stall` to the hazard unit, which freezes every pipeline register F through W. A watchdog bounds the wait and flags a bus error if the slave never answers.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ+WAIT before the access is aborted. 0 disables the watchdog. Range 0..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `memen`  in  1  M-stage memory access valid. Held stable by the stalled pipeline.
- `memwr`  in  1  1 = store, 0 = load.
- `sel`  in  4  byte write enables from the byte-select logic. Meaningful for stores only.
- `addr`  in  32  effective address (M-stage ALU result).
- `wdata`  in  32  byte-lane-aligned store data.
- `rdata`  out  32  registered read word, feeds the load-extract logic.
- `stall`  out  1  freeze request to the hazard unit.
- `bus_err`  out  1  one-cycle pulse, timed-out access.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  bus write.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  bus address.
- `data_wdata`  out  32  bus write data.
- `data_addr_ok`  in  1  slave accepted the request this cycle.
- `data_data_ok`  in  1  read data valid, or write complete, this cycle.
- `data_rdata`  in  32  bus read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - If `memen`=1: capture `memwr`, size, address and `wdata` into registers. Next state REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `data_req`=1, with all bus outputs driven from the captured registers and held stable.
  - `data_addr_ok`=1 and `data_data_ok`=1 in the same cycle: next state DONE.
  - `data_addr_ok`=1 alone: next state WAIT.
  - Neither: stay in REQ.
- **WAIT**
  - `data_req`=0.
  - On `data_data_ok`=1: next state DONE.
- **DONE**
  - Next state IDLE unconditionally. This is the single cycle in which the pipeline advances.
- `rdata` capture:
  - `data_rdata` is latched into `rdata` on the edge where `data_data_ok`=1 and `data_wr`=0.
  - `rdata` holds that value until the next load completes.
  - Writes do not change `rdata`.
- Size and address mapping:
  - Loads: `data_size`=2 and `data_addr`={addr[31:2],2'b00}.
  - Stores with `sel` 0001, 0010, 0100 or 1000: `data_size`=0, offset 0, 1, 2 or 3 respectively.
  - Stores with `sel` 0011 or 1100: `data_size`=1, offset 0 or 2 respectively.
  - Stores with `sel` 1111 or any other pattern: `data_size`=2, offset 0.
  - Store address is `data_addr`={addr[31:2],offset}.
  - `data_wdata`=`wdata`, unmodified.
- `stall` (combinational):
  - `memen` in IDLE.
  - 1 in REQ and WAIT.
  - 0 in DONE.
  - Forced 0 while `rst`=1.
- Watchdog:
  - A 16-bit counter clears in IDLE and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` (with `TIMEOUT`≠0), the FSM goes to DONE regardless of the handshake, `rdata` is loaded with 32'hDEADBEEF, and `bus_err`=1 for the DONE cycle.
- Late handshakes: a `data_data_ok` or `data_addr_ok` arriving in IDLE or DONE is ignored.
- Reset mid-operation: `rst` in any state forces IDLE on the next edge. No completion or error is reported for the aborted access.

## Timing
- Reset values: `rdata`=0, `bus_err`=0, `data_req`=0, `data_wr`=0, `data_size`=0, `data_addr`=0, `data_wdata`=0, `stall`=0.
- Minimum latency, with the slave answering in its first REQ cycle:
  - cycle 0: IDLE, `stall`=1.
  - cycle 1: REQ, `stall`=1.
  - cycle 2: DONE, `stall`=0, `rdata` valid.
  - Net cost: two stall cycles per memory access.
- `data_req` is high for at least one cycle. It stays high exactly until the cycle in which `data_addr_ok` is sampled high, or until timeout.
- Bus outputs are registered and change only on entry to REQ.
- Back-to-back accesses: DONE → IDLE. The next `memen` is first seen in the IDLE cycle, so there is never a request in DONE.

## Test plan
- **Load word, immediate slave.** `addr`=0x80001004, `memwr`=0; slave asserts `addr_ok`, `data_ok` and `data_rdata`=0x12345678 in the first REQ cycle.
  - Required: `data_req` high for 1 cycle; `data_addr`=0x80001004, `size`=2, `wr`=0.
  - Required: `stall` = 1,1,0; `rdata`=0x12345678 in DONE.
- **Byte store with delayed accept.** `sel`=0100, `addr`=0x80000010, `wdata`=0x00AB0000; `addr_ok` delayed 3 cycles.
  - Required: `data_addr`=0x80000012, `size`=0, `wr`=1, `data_wdata`=0x00AB0000.
  - Required: `data_req` held 4 cycles with outputs stable; `rdata` unchanged.
- **Halfword store.** `sel`=1100, `addr`=0x00000100.
  - Required: `data_addr`=0x00000102, `size`=1.
- **Split transaction.** Load with `data_ok` arriving 5 cycles after `addr_ok`, `data_rdata`=0xCAFEF00D, then an immediate second load.
  - Required: `stall` high throughout REQ+WAIT; `rdata`=0xCAFEF00D.
  - Required: one IDLE cycle before the second REQ.
- **Timeout.** `TIMEOUT`=8; `addr_ok` given, `data_ok` never given.
  - Required: DONE 8 cycles after entering REQ; `bus_err` pulses once; `rdata`=0xDEADBEEF.
- **Reset during WAIT.** Assert `rst` for 1 cycle, then drive a stale `data_ok`.
  - Required: next cycle IDLE, `stall`=0, `data_req`=0.
  - Required: stale `data_ok` ignored, `rdata`=0.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: M-stage memory port to SRAM-like addr_ok/data_ok bus bridge.
// One bus transaction per access, pipeline stall while outstanding, and a
// watchdog that aborts with a bus error if the slave never answers.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic        memwr,
    input  logic [3:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_bus_err;
    logic               r_req;
    logic               r_wr;
    logic [1:0]         r_size;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [1:0]         w_size;
    logic [1:0]         w_offset;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic               w_unused;

    // Byte offset within the word is only defined by the store byte selects.
    assign w_unused = ^addr[1:0];

    // Derive bus transfer size and byte offset from the access type and byte selects.
    always_comb begin
        w_size   = 2'd2;
        w_offset = 2'd0;
        if (memwr) begin
            unique case (sel)
                4'b0001: begin w_size = 2'd0; w_offset = 2'd0; end
                4'b0010: begin w_size = 2'd0; w_offset = 2'd1; end
                4'b0100: begin w_size = 2'd0; w_offset = 2'd2; end
                4'b1000: begin w_size = 2'd0; w_offset = 2'd3; end
                4'b0011: begin w_size = 2'd1; w_offset = 2'd0; end
                4'b1100: begin w_size = 2'd1; w_offset = 2'd2; end
                default: begin w_size = 2'd2; w_offset = 2'd0; end
            endcase
        end
    end

    // Watchdog fires on the cycle that would bring the REQ+WAIT count to TIMEOUT.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT_V != '0) && (w_cnt_inc == TIMEOUT_V);

    // Transaction FSM with registered bus outputs, read data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
            r_req     <= 1'b0;
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_bus_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (memen) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_wr    <= memwr;
                        r_size  <= w_size;
                        r_addr  <= {addr[31:2], w_offset};
                        r_wdata <= wdata;
                    end
                end
                REQ: begin
                    r_cnt <= w_cnt_inc;
                    if (data_addr_ok && data_data_ok) begin
                        r_req   <= 1'b0;
                        r_state <= DONE;
                        if (!r_wr) r_rdata <= data_rdata;
                    end else if (data_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_state   <= DONE;
                        r_rdata   <= ERR_WORD;
                        r_bus_err <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (data_data_ok) begin
                        r_state <= DONE;
                        if (!r_wr) r_rdata <= data_rdata;
                    end else if (w_timeout) begin
                        r_state   <= DONE;
                        r_rdata   <= ERR_WORD;
                        r_bus_err <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Hazard-unit freeze: pending request in IDLE, or an outstanding bus transaction.
    assign stall = !rst && (((r_state == IDLE) && memen) || (r_state == REQ) || (r_state == WAIT));

    assign rdata      = r_rdata;
    assign bus_err    = r_bus_err;
    assign data_req   = r_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: the driver pushes expected bus requests and
// completions, and a negedge monitor pops and compares as the DUT presents them.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memen;
    logic        memwr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .memen(memen), .memwr(memwr), .sel(sel),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .bus_err(bus_err), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
        bit          b2b;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          req_len;
        int          stall_len;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          req_len = 0;
    int          stall_run = 0;
    bit          stable = 1'b1;
    logic        p_req = 1'b0;
    logic        p_stall = 1'b0;
    logic        p_rst = 1'b0;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_size;
    logic        s_wr;
    req_t        r;
    cmp_t        c;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (data_req && !p_req) begin
                if (req_q.size() == 0) fail_now("unexpected_req");
                else begin
                    r = req_q.pop_front();
                    chk("req_addr",  data_addr,  r.addr);
                    chk("req_size",  32'(data_size), 32'(r.size));
                    chk("req_wr",    32'(data_wr),   32'(r.wr));
                    chk("req_wdata", data_wdata, r.wdata);
                    if (r.b2b) chk("b2b_gap", 32'(cyc - done_cyc), 32'd2);
                end
                s_addr = data_addr; s_wdata = data_wdata; s_size = data_size; s_wr = data_wr;
                req_len = 1;
                stable  = 1'b1;
            end else if (data_req && p_req) begin
                req_len++;
                if (data_addr !== s_addr || data_wdata !== s_wdata ||
                    data_size !== s_size || data_wr !== s_wr) stable = 1'b0;
            end

            if (p_stall && !stall && !rst && !p_rst) begin
                if (cmp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    c = cmp_q.pop_front();
                    chk("done_rdata",     rdata,            c.rdata);
                    chk("done_bus_err",   32'(bus_err),     32'(c.err));
                    chk("done_req_len",   32'(req_len),     32'(c.req_len));
                    chk("done_stall_len", 32'(stall_run),   32'(c.stall_len));
                    chk("done_req_stable", 32'(stable),     32'd1);
                end
                done_cyc = cyc;
            end else if (bus_err) begin
                fail_now("stray_bus_err");
            end

            if (stall) stall_run++;
            else stall_run = 0;
        end
        p_req   = data_req;
        p_stall = stall;
        p_rst   = rst;
    end

    function automatic req_t mk_req(input logic [31:0] a, input logic [1:0] s,
                                    input logic w, input logic [31:0] wd, input bit b2b);
        req_t x;
        x.addr = a; x.size = s; x.wr = w; x.wdata = wd; x.b2b = b2b;
        return x;
    endfunction

    function automatic cmp_t mk_cmp(input logic [31:0] rd, input logic e,
                                    input int rl, input int sl);
        cmp_t x;
        x.rdata = rd; x.err = e; x.req_len = rl; x.stall_len = sl;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory access; returns #1 after the edge that entered DONE.
    task automatic access(input logic wr, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] wd, input int acc_dly, input int data_dly,
                          input logic [31:0] rd, input bit no_data);
        int k;
        memen = 1'b1; memwr = wr; sel = s; addr = a; wdata = wd;
        k = 0;
        do begin tick(); k++; end while (!data_req && k < 4);
        if (!data_req) fail_now("req_never_issued");
        repeat (acc_dly) tick();
        data_addr_ok = 1'b1;
        data_data_ok = (data_dly == 0) && !no_data;
        data_rdata   = rd;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (no_data) begin
            k = 0;
            while (stall && k < 20) begin tick(); k++; end
            if (stall) fail_now("timeout_never_done");
        end else if (data_dly > 0) begin
            repeat (data_dly - 1) tick();
            data_data_ok = 1'b1;
            data_rdata   = rd;
            tick();
            data_data_ok = 1'b0;
        end
        memen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; memen = 1'b1; memwr = 1'b0; sel = 4'b0; addr = '0; wdata = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata",   rdata,             32'h0);
        chk("rst_bus_err", 32'(bus_err),      32'h0);
        chk("rst_req",     32'(data_req),     32'h0);
        chk("rst_wr",      32'(data_wr),      32'h0);
        chk("rst_size",    32'(data_size),    32'h0);
        chk("rst_addr",    data_addr,         32'h0);
        chk("rst_wdata",   data_wdata,        32'h0);
        chk("rst_stall",   32'(stall),        32'h0);
        memen = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // Load word, immediate slave
        req_q.push_back(mk_req(32'h8000_1004, 2'd2, 1'b0, 32'h0, 1'b0));
        cmp_q.push_back(mk_cmp(32'h1234_5678, 1'b0, 1, 2));
        access(1'b0, 4'b1111, 32'h8000_1004, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
        repeat (2) tick();

        // Byte store, accept delayed 3 cycles; rdata must not change
        req_q.push_back(mk_req(32'h8000_0012, 2'd0, 1'b1, 32'h00AB_0000, 1'b0));
        cmp_q.push_back(mk_cmp(32'h1234_5678, 1'b0, 4, 5));
        access(1'b1, 4'b0100, 32'h8000_0010, 32'h00AB_0000, 3, 0, 32'hFFFF_FFFF, 1'b0);
        repeat (2) tick();

        // Halfword store, upper half
        req_q.push_back(mk_req(32'h0000_0102, 2'd1, 1'b1, 32'hBEEF_0000, 1'b0));
        cmp_q.push_back(mk_cmp(32'h1234_5678, 1'b0, 1, 2));
        access(1'b1, 4'b1100, 32'h0000_0100, 32'hBEEF_0000, 0, 0, 32'h5555_5555, 1'b0);
        repeat (2) tick();

        // Byte store, lane 1
        req_q.push_back(mk_req(32'h0000_0011, 2'd0, 1'b1, 32'h0000_7700, 1'b0));
        cmp_q.push_back(mk_cmp(32'h1234_5678, 1'b0, 1, 2));
        access(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_7700, 0, 0, 32'h0, 1'b0);
        repeat (2) tick();

        // Irregular byte selects fall back to word at offset 0
        req_q.push_back(mk_req(32'h0000_0204, 2'd2, 1'b1, 32'h00CC_DD00, 1'b0));
        cmp_q.push_back(mk_cmp(32'h1234_5678, 1'b0, 1, 2));
        access(1'b1, 4'b0110, 32'h0000_0207, 32'h00CC_DD00, 0, 0, 32'h0, 1'b0);
        repeat (2) tick();

        // Split load, data 5 cycles after accept, then back-to-back load
        req_q.push_back(mk_req(32'h0000_2008, 2'd2, 1'b0, 32'h0, 1'b0));
        cmp_q.push_back(mk_cmp(32'hCAFE_F00D, 1'b0, 1, 7));
        access(1'b0, 4'b0000, 32'h0000_2008, 32'h0, 0, 5, 32'hCAFE_F00D, 1'b0);
        req_q.push_back(mk_req(32'h0000_2010, 2'd2, 1'b0, 32'h0, 1'b1));
        cmp_q.push_back(mk_cmp(32'h1122_3344, 1'b0, 1, 2));
        access(1'b0, 4'b0000, 32'h0000_2013, 32'h0, 0, 0, 32'h1122_3344, 1'b0);
        repeat (2) tick();

        // Timeout: accepted but data never returned
        req_q.push_back(mk_req(32'h0000_0040, 2'd2, 1'b0, 32'h0, 1'b0));
        cmp_q.push_back(mk_cmp(32'hDEAD_BEEF, 1'b1, 1, 9));
        access(1'b0, 4'b0000, 32'h0000_0040, 32'h0, 0, 0, 32'h0, 1'b1);
        repeat (3) tick();

        // Reset during WAIT, then a stale data_ok in IDLE
        req_q.push_back(mk_req(32'h0000_0050, 2'd2, 1'b0, 32'h0, 1'b0));
        memen = 1'b1; memwr = 1'b0; sel = 4'b0; addr = 32'h0000_0050; wdata = '0;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        tick();
        rst = 1'b1;
        memen = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall),    32'h0);
        chk("post_rst_req",   32'(data_req), 32'h0);
        chk("post_rst_rdata", rdata,         32'h0);
        @(posedge clk); #1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBAD0_BAD0;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_ok_rdata", rdata,           32'h0);
        chk("stale_ok_stall", 32'(stall),      32'h0);
        chk("stale_ok_err",   32'(bus_err),    32'h0);
        repeat (3) tick();

        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("cmp_q_empty", 32'(cmp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
